// File: rtl/serial_frame_if.sv
// Handshake bundle between the serial front end and the frame controller:
// bit-rate enable and serial line in, header/payload status and per-port data out.
interface serial_frame_if #(
   parameter int PORT_W = 2,
   parameter int LEN_W  = 4
);
   localparam int NPORT = 2**PORT_W;

   logic              clk_en;
   logic              serin;
   logic              busy;
   logic [PORT_W-1:0] port_num;
   logic [LEN_W-1:0]  data_len;
   logic [LEN_W-1:0]  rem_cnt;
   logic [NPORT-1:0]  p_out;
   logic [NPORT-1:0]  p_valid;
   logic              done;
   logic              zero_len;

   modport master (
      output clk_en, serin,
      input  busy, port_num, data_len, rem_cnt, p_out, p_valid, done, zero_len
   );

   modport slave (
      input  clk_en, serin,
      output busy, port_num, data_len, rem_cnt, p_out, p_valid, done, zero_len
   );
endinterface

// File: rtl/serial_frame_ctrl.sv
// Serial frame controller: start bit, MSB-first port and length headers, then
// payload bits routed to the addressed output port with a one-clk valid pulse.
module serial_frame_ctrl #(
   parameter int PORT_W = 2,
   parameter int LEN_W  = 4
) (
   input  logic         clk,
   input  logic         rst,
   serial_frame_if.slave bus
);
   localparam int NPORT = 2**PORT_W;
   localparam int MAX_W = (PORT_W > LEN_W) ? PORT_W : LEN_W;
   localparam int CNT_W = $clog2(MAX_W) + 1;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      PORT = 2'd1,
      LEN  = 2'd2,
      DATA = 2'd3
   } state_t;

   state_t            state_q;
   logic [CNT_W-1:0]  cnt_q;
   logic [PORT_W-1:0] port_sh_q;
   logic [LEN_W-1:0]  len_sh_q;
   logic              busy_q;
   logic [PORT_W-1:0] port_num_q;
   logic [LEN_W-1:0]  data_len_q;
   logic [LEN_W-1:0]  rem_cnt_q;
   logic [NPORT-1:0]  p_out_q;
   logic [NPORT-1:0]  p_valid_q;
   logic              done_q;
   logic              zero_len_q;

   logic [PORT_W-1:0] port_next_s;
   logic [LEN_W-1:0]  len_next_s;

   // Shadow values including the bit sampled on this step, so the commit sees the full field.
   assign port_next_s = (port_sh_q << 1) | PORT_W'(bus.serin);
   assign len_next_s  = (len_sh_q << 1) | LEN_W'(bus.serin);

   // Frame sequencer with all outputs registered; pulses drop every clk regardless of clk_en.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= IDLE;
         cnt_q      <= {CNT_W{1'b0}};
         port_sh_q  <= {PORT_W{1'b0}};
         len_sh_q   <= {LEN_W{1'b0}};
         busy_q     <= 1'b0;
         port_num_q <= {PORT_W{1'b0}};
         data_len_q <= {LEN_W{1'b0}};
         rem_cnt_q  <= {LEN_W{1'b0}};
         p_out_q    <= {NPORT{1'b0}};
         p_valid_q  <= {NPORT{1'b0}};
         done_q     <= 1'b0;
         zero_len_q <= 1'b0;
      end else begin
         p_valid_q  <= {NPORT{1'b0}};
         done_q     <= 1'b0;
         zero_len_q <= 1'b0;
         if (bus.clk_en) begin
            case (state_q)
               IDLE: begin
                  if (bus.serin == 1'b0) begin
                     state_q <= PORT;
                     busy_q  <= 1'b1;
                     cnt_q   <= {CNT_W{1'b0}};
                  end
               end
               PORT: begin
                  port_sh_q <= port_next_s;
                  cnt_q     <= cnt_q + CNT_W'(1);
                  if (cnt_q == CNT_W'(PORT_W - 1)) begin
                     state_q <= LEN;
                     cnt_q   <= {CNT_W{1'b0}};
                  end
               end
               LEN: begin
                  len_sh_q <= len_next_s;
                  cnt_q    <= cnt_q + CNT_W'(1);
                  if (cnt_q == CNT_W'(LEN_W - 1)) begin
                     cnt_q      <= {CNT_W{1'b0}};
                     port_num_q <= port_sh_q;
                     data_len_q <= len_next_s;
                     rem_cnt_q  <= len_next_s;
                     if (len_next_s == {LEN_W{1'b0}}) begin
                        state_q    <= IDLE;
                        busy_q     <= 1'b0;
                        done_q     <= 1'b1;
                        zero_len_q <= 1'b1;
                     end else begin
                        state_q <= DATA;
                     end
                  end
               end
               DATA: begin
                  p_out_q[port_num_q]   <= bus.serin;
                  p_valid_q[port_num_q] <= 1'b1;
                  rem_cnt_q             <= rem_cnt_q - LEN_W'(1);
                  if (rem_cnt_q == LEN_W'(1)) begin
                     state_q <= IDLE;
                     busy_q  <= 1'b0;
                     done_q  <= 1'b1;
                  end
               end
               default: begin
                  state_q <= IDLE;
                  busy_q  <= 1'b0;
               end
            endcase
         end
      end
   end

   assign bus.busy     = busy_q;
   assign bus.port_num = port_num_q;
   assign bus.data_len = data_len_q;
   assign bus.rem_cnt  = rem_cnt_q;
   assign bus.p_out    = p_out_q;
   assign bus.p_valid  = p_valid_q;
   assign bus.done     = done_q;
   assign bus.zero_len = zero_len_q;
endmodule
